// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, select codes,
// opcode/funct constants and the instruction decode helpers.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_e;

    // Extender modes
    localparam logic [1:0] EXTOP_UNSIGNED = 2'b00;
    localparam logic [1:0] EXTOP_SIGNED   = 2'b01;
    localparam logic [1:0] EXTOP_INST     = 2'b10;

    // ALU functions
    localparam logic [2:0] ALUOP_ADD = 3'd0;
    localparam logic [2:0] ALUOP_SUB = 3'd1;
    localparam logic [2:0] ALUOP_OR  = 3'd2;
    localparam logic [2:0] ALUOP_SLT = 3'd3;
    localparam logic [2:0] ALUOP_LUI = 3'd4;

    // Next-PC selects
    localparam logic [1:0] NPC_PC4    = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JUMP   = 2'd2;
    localparam logic [1:0] NPC_REG    = 2'd3;

    // Register-file write address / data selects
    localparam logic [1:0] REGDST_RT    = 2'd0;
    localparam logic [1:0] REGDST_RD    = 2'd1;
    localparam logic [1:0] REGDST_RA    = 2'd2;
    localparam logic [1:0] MEMTOREG_ALU = 2'd0;
    localparam logic [1:0] MEMTOREG_MEM = 2'd1;
    localparam logic [1:0] MEMTOREG_PC4 = 2'd2;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type function codes
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_JR   = 6'b001000;

    typedef enum logic [3:0] {
        K_ADDU, K_SUBU, K_SLT, K_JR,
        K_ORI, K_ADDIU, K_LUI, K_LW, K_SW, K_BEQ,
        K_J, K_JAL, K_ILLEGAL
    } inst_e;

    // Classify the instruction held in IR.
    function automatic inst_e decode(input logic [5:0] op, input logic [5:0] funct);
        inst_e k;
        k = K_ILLEGAL;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FUNCT_ADDU: k = K_ADDU;
                    FUNCT_SUBU: k = K_SUBU;
                    FUNCT_SLT:  k = K_SLT;
                    FUNCT_JR:   k = K_JR;
                    default:    k = K_ILLEGAL;
                endcase
            end
            OP_ORI:   k = K_ORI;
            OP_ADDIU: k = K_ADDIU;
            OP_LUI:   k = K_LUI;
            OP_LW:    k = K_LW;
            OP_SW:    k = K_SW;
            OP_BEQ:   k = K_BEQ;
            OP_J:     k = K_J;
            OP_JAL:   k = K_JAL;
            default:  k = K_ILLEGAL;
        endcase
        return k;
    endfunction

    // Extender mode depends on the opcode alone, so it is stable all instruction long.
    function automatic logic [1:0] ext_mode(input logic [5:0] op);
        case (op)
            OP_ORI, OP_LUI:                 return EXTOP_UNSIGNED;
            OP_ADDIU, OP_LW, OP_SW, OP_BEQ: return EXTOP_SIGNED;
            default:                        return EXTOP_INST;
        endcase
    endfunction

    function automatic logic [2:0] alu_func(input inst_e k);
        case (k)
            K_SUBU, K_BEQ: return ALUOP_SUB;
            K_SLT:         return ALUOP_SLT;
            K_ORI:         return ALUOP_OR;
            K_LUI:         return ALUOP_LUI;
            default:       return ALUOP_ADD;
        endcase
    endfunction

    function automatic logic uses_imm(input inst_e k);
        return (k == K_ORI) || (k == K_ADDIU) || (k == K_LUI) || (k == K_LW) || (k == K_SW);
    endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: one state register plus a
// combinational next-state and Moore output decode (PCWr in beq EX also uses Zero).
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RegWr,
    output logic       MemWr,
    output logic [1:0] EXTOp,
    output logic [2:0] ALUOp,
    output logic       ALUSrcB,
    output logic [1:0] RegDst,
    output logic [1:0] MemToReg,
    output logic [1:0] NPCOp,
    output logic       InstDone,
    output logic       Illegal,
    output logic [2:0] State
);

    state_e state_q, state_d;
    inst_e  inst;

    assign inst  = decode(Op, Funct);
    assign State = state_q;

    // State register; reset parks the FSM in instruction fetch.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (rst) state_q <= S_IF;
        else     state_q <= state_d;
    end

    // Next-state and output decode; reset forces every output to zero.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
        state_d  = state_q;
        PCWr     = 1'b0;
        IRWr     = 1'b0;
        RegWr    = 1'b0;
        MemWr    = 1'b0;
        EXTOp    = ext_mode(Op);
        ALUOp    = ALUOP_ADD;
        ALUSrcB  = 1'b0;
        RegDst   = REGDST_RT;
        MemToReg = MEMTOREG_ALU;
        NPCOp    = NPC_PC4;
        InstDone = 1'b0;
        Illegal  = 1'b0;

        // ALU controls are held from EX through WB so the ALU result stays put.
        if (state_q == S_EX || state_q == S_MEM || state_q == S_WB) begin
            ALUOp   = alu_func(inst);
            ALUSrcB = uses_imm(inst);
        end

        case (state_q)
            S_IF: begin
                PCWr    = 1'b1;
                IRWr    = 1'b1;
                state_d = S_ID;
            end
            S_ID: begin
                case (inst)
                    K_J: begin
                        PCWr     = 1'b1;
                        NPCOp    = NPC_JUMP;
                        InstDone = 1'b1;
                        state_d  = S_IF;
                    end
                    K_JAL: begin
                        PCWr     = 1'b1;
                        NPCOp    = NPC_JUMP;
                        RegWr    = 1'b1;
                        RegDst   = REGDST_RA;
                        MemToReg = MEMTOREG_PC4;
                        InstDone = 1'b1;
                        state_d  = S_IF;
                    end
                    K_JR: begin
                        PCWr     = 1'b1;
                        NPCOp    = NPC_REG;
                        InstDone = 1'b1;
                        state_d  = S_IF;
                    end
                    K_ILLEGAL: begin
                        Illegal = 1'b1;
                        state_d = S_IF;
                    end
                    default: state_d = S_EX;
                endcase
            end
            S_EX: begin
                case (inst)
                    K_BEQ: begin
                        PCWr     = Zero;
                        NPCOp    = NPC_BRANCH;
                        InstDone = 1'b1;
                        state_d  = S_IF;
                    end
                    K_LW, K_SW: state_d = S_MEM;
                    default:    state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (inst == K_SW) begin
                    MemWr    = 1'b1;
                    InstDone = 1'b1;
                    state_d  = S_IF;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                RegWr    = 1'b1;
                InstDone = 1'b1;
                state_d  = S_IF;
                if (inst == K_ADDU || inst == K_SUBU || inst == K_SLT) RegDst = REGDST_RD;
                if (inst == K_LW) MemToReg = MEMTOREG_MEM;
            end
            default: state_d = S_IF;
        endcase

        if (rst) begin
            PCWr     = 1'b0;
            IRWr     = 1'b0;
            RegWr    = 1'b0;
            MemWr    = 1'b0;
            EXTOp    = 2'b00;
            ALUOp    = 3'b000;
            ALUSrcB  = 1'b0;
            RegDst   = 2'b00;
            MemToReg = 2'b00;
            NPCOp    = 2'b00;
            InstDone = 1'b0;
            Illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed literal checks followed by a
// random instruction stream compared cycle by cycle against an instruction-level model.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst, Zero;
    logic [5:0] Op, Funct;
    logic       PCWr, IRWr, RegWr, MemWr, ALUSrcB, InstDone, Illegal;
    logic [1:0] EXTOp, RegDst, MemToReg, NPCOp;
    logic [2:0] ALUOp, State;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
        .PCWr(PCWr), .IRWr(IRWr), .RegWr(RegWr), .MemWr(MemWr),
        .EXTOp(EXTOp), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .RegDst(RegDst),
        .MemToReg(MemToReg), .NPCOp(NPCOp), .InstDone(InstDone),
        .Illegal(Illegal), .State(State)
    );

    typedef enum int {
        I_ADDU, I_SUBU, I_SLT, I_JR, I_ORI, I_ADDIU, I_LUI,
        I_LW, I_SW, I_BEQ, I_J, I_JAL, I_ILL
    } ins_e;

    typedef struct packed {
        logic       pcwr, irwr, regwr, memwr;
        logic [1:0] extop;
        logic [2:0] aluop;
        logic       alusrcb;
        logic [1:0] regdst, memtoreg, npcop;
        logic       done, illegal;
        logic [2:0] state;
    } outs_t;

    int    n_cmp = 0;
    int    n_bad = 0;
    outs_t e;
    logic  exp_valid = 1'b0;
    logic  chk_alu, chk_sel, chk_npc, chk_state;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, required %0d", name, $time, act, req);
        end
    endtask

    // ---------------- behavioural model (instruction level) ----------------
    function automatic int cpi(input ins_e i);
        case (i)
            I_J, I_JAL, I_JR, I_ILL: return 2;
            I_BEQ:                   return 3;
            I_LW:                    return 5;
            default:                 return 4;
        endcase
    endfunction

    function automatic logic [1:0] ext_of(input logic [5:0] op);
        case (op)
            6'b001101, 6'b001111:                       return 2'b00;
            6'b001001, 6'b100011, 6'b101011, 6'b000100: return 2'b01;
            default:                                    return 2'b10;
        endcase
    endfunction

    // ALU codes: ADD=0 SUB=1 OR=2 SLT=3 LUI=4
    function automatic logic [2:0] alu_of(input ins_e i);
        case (i)
            I_SUBU, I_BEQ: return 3'd1;
            I_SLT:         return 3'd3;
            I_ORI:         return 3'd2;
            I_LUI:         return 3'd4;
            default:       return 3'd0;
        endcase
    endfunction

    function automatic logic writes_reg(input ins_e i);
        return i inside {I_ADDU, I_SUBU, I_SLT, I_ORI, I_ADDIU, I_LUI, I_LW};
    endfunction

    // Expected outputs in cycle k (0 = fetch) of instruction i.
    function automatic outs_t model(input ins_e i, input int k, input logic z, input logic [5:0] op);
        outs_t o;
        logic  last;
        o    = '0;
        last = (k == cpi(i) - 1);
        // states visited: IF, ID, EX, then MEM only for memory ops, then WB
        if (k < 3)                       o.state = 3'(k);
        else if (k == 3 && (i == I_LW || i == I_SW)) o.state = 3'd3;
        else                             o.state = 3'd4;
        o.extop = ext_of(op);
        if (k == 0) begin
            o.pcwr = 1'b1;
            o.irwr = 1'b1;
        end
        if (k >= 2) begin
            o.aluop   = alu_of(i);
            o.alusrcb = i inside {I_ORI, I_ADDIU, I_LUI, I_LW, I_SW};
        end
        if (k == 1 && i inside {I_J, I_JAL}) begin o.pcwr = 1'b1; o.npcop = 2'd2; end
        if (k == 1 && i == I_JAL) begin o.regwr = 1'b1; o.regdst = 2'd2; o.memtoreg = 2'd2; end
        if (k == 1 && i == I_JR)  begin o.pcwr = 1'b1; o.npcop = 2'd3; end
        if (k == 1 && i == I_ILL) o.illegal = 1'b1;
        if (k == 2 && i == I_BEQ) begin o.pcwr = z; o.npcop = 2'd1; end
        if (k == 3 && i == I_SW)  o.memwr = 1'b1;
        if (last && writes_reg(i)) begin
            o.regwr    = 1'b1;
            o.regdst   = (i inside {I_ADDU, I_SUBU, I_SLT}) ? 2'd1 : 2'd0;
            o.memtoreg = (i == I_LW) ? 2'd1 : 2'd0;
        end
        o.done = last && (i != I_ILL);
        return o;
    endfunction

    function automatic logic legal_op(input logic [5:0] op);
        return op inside {6'b000000, 6'b001101, 6'b001001, 6'b001111, 6'b100011,
                          6'b101011, 6'b000100, 6'b000010, 6'b000011};
    endfunction

    task automatic pick(input ins_e i, output logic [5:0] op, output logic [5:0] fn);
        fn = 6'($urandom);
        op = 6'b000000;
        case (i)
            I_ADDU:  fn = 6'b100001;
            I_SUBU:  fn = 6'b100011;
            I_SLT:   fn = 6'b101010;
            I_JR:    fn = 6'b001000;
            I_ORI:   op = 6'b001101;
            I_ADDIU: op = 6'b001001;
            I_LUI:   op = 6'b001111;
            I_LW:    op = 6'b100011;
            I_SW:    op = 6'b101011;
            I_BEQ:   op = 6'b000100;
            I_J:     op = 6'b000010;
            I_JAL:   op = 6'b000011;
            default: begin
                if ($urandom_range(0, 1) == 0) begin
                    while (fn inside {6'b100001, 6'b100011, 6'b101010, 6'b001000}) fn = 6'($urandom);
                end else begin
                    op = 6'($urandom);
                    while (legal_op(op)) op = 6'($urandom);
                end
            end
        endcase
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (exp_valid) begin
            check("PCWr",     int'(PCWr),     int'(e.pcwr));
            check("IRWr",     int'(IRWr),     int'(e.irwr));
            check("RegWr",    int'(RegWr),    int'(e.regwr));
            check("MemWr",    int'(MemWr),    int'(e.memwr));
            check("EXTOp",    int'(EXTOp),    int'(e.extop));
            check("InstDone", int'(InstDone), int'(e.done));
            check("Illegal",  int'(Illegal),  int'(e.illegal));
            if (chk_alu) begin
                check("ALUOp",   int'(ALUOp),   int'(e.aluop));
                check("ALUSrcB", int'(ALUSrcB), int'(e.alusrcb));
            end
            if (chk_sel) begin
                check("RegDst",   int'(RegDst),   int'(e.regdst));
                check("MemToReg", int'(MemToReg), int'(e.memtoreg));
            end
            if (chk_npc)   check("NPCOp", int'(NPCOp), int'(e.npcop));
            if (chk_state) check("State", int'(State), int'(e.state));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic r, input logic [5:0] op, input logic [5:0] fn, input logic z);
        @(posedge clk);
        #1;
        rst   = r;
        Op    = op;
        Funct = fn;
        Zero  = z;
    endtask

    task automatic cyc(input logic r, input logic [5:0] op, input logic [5:0] fn, input logic z);
        drive(r, op, fn, z);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] op, fn;
        logic       z;
        ins_e       ins;
        int         n;
        outs_t      act;

        rst = 1'b1; Op = 6'b100011; Funct = 6'b0; Zero = 1'b0;

        // Reset held three cycles with a lw opcode present
        for (int c = 0; c < 3; c++) begin
            cyc(1'b1, 6'b100011, 6'b0, 1'b0);
            act = {PCWr, IRWr, RegWr, MemWr, EXTOp, ALUOp, ALUSrcB, RegDst,
                   MemToReg, NPCOp, InstDone, Illegal, State};
            check("rst_outputs", int'(act[20:3]), 0);
            check("rst_state", int'(State), 0);
        end

        // lw: five cycles through every state
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 6'b100011, 6'b0, 1'b0);
            check("lw_state", int'(State), k);
            check("lw_extop", int'(EXTOp), 1);
            check("lw_regwr", int'(RegWr), (k == 4) ? 1 : 0);
            check("lw_done",  int'(InstDone), (k == 4) ? 1 : 0);
            if (k == 0) check("lw_if_wr", int'({PCWr, IRWr}), 3);
            if (k == 4) check("lw_memtoreg", int'(MemToReg), 1);
        end

        // beq taken then not taken
        for (int t = 0; t < 2; t++) begin
            for (int k = 0; k < 3; k++) begin
                cyc(1'b0, 6'b000100, 6'b0, (t == 0));
                if (k == 2) begin
                    check("beq_pcwr",  int'(PCWr), (t == 0) ? 1 : 0);
                    check("beq_npcop", int'(NPCOp), 1);
                    check("beq_done",  int'(InstDone), 1);
                end
            end
        end

        // jal: two cycles
        cyc(1'b0, 6'b000011, 6'b0, 1'b0);
        check("jal_if_state", int'(State), 0);
        cyc(1'b0, 6'b000011, 6'b0, 1'b0);
        check("jal_id", int'({PCWr, NPCOp, RegWr, RegDst, MemToReg, InstDone}),
              int'({1'b1, 2'd2, 1'b1, 2'd2, 2'd2, 1'b1}));

        // ori then addiu
        for (int t = 0; t < 2; t++) begin
            for (int k = 0; k < 4; k++) begin
                cyc(1'b0, (t == 0) ? 6'b001101 : 6'b001001, 6'b0, 1'b0);
                check("imm_extop", int'(EXTOp), t);
                if (k == 3) check("imm_wb", int'({State, RegWr, RegDst}), int'({3'd4, 1'b1, 2'd0}));
            end
        end

        // illegal opcode
        cyc(1'b0, 6'b111111, 6'b0, 1'b0);
        cyc(1'b0, 6'b111111, 6'b0, 1'b0);
        check("ill_pulse", int'({Illegal, PCWr, IRWr, RegWr, MemWr, InstDone}), 32);

        // sw aborted by reset in MEM
        for (int k = 0; k < 3; k++) cyc(1'b0, 6'b101011, 6'b0, 1'b0);
        check("sw_ex_state", int'(State), 2);
        cyc(1'b1, 6'b101011, 6'b0, 1'b0);
        check("sw_abort_memwr", int'(MemWr), 0);
        cyc(1'b1, 6'b101011, 6'b0, 1'b0);
        check("sw_abort_state", int'(State), 0);

        // Random instruction stream with occasional reset aborts
        for (int j = 0; j < 400; j++) begin
            ins = ins_e'($urandom_range(0, 12));
            pick(ins, op, fn);
            for (int k = 0; k < cpi(ins); k++) begin
                if (k > 0 && $urandom_range(0, 39) == 0) begin
                    n = $urandom_range(1, 3);
                    for (int r = 0; r < n; r++) begin
                        drive(1'b1, 6'($urandom), 6'($urandom), 1'($urandom));
                        e = '0;
                        chk_alu = 1'b1; chk_sel = 1'b1; chk_npc = 1'b1;
                        chk_state = (r > 0);
                        exp_valid = 1'b1;
                    end
                    break;
                end
                z = 1'($urandom);
                drive(1'b0, op, fn, z);
                e = model(ins, k, z, op);
                chk_alu   = (k >= 2);
                chk_sel   = e.regwr;
                chk_npc   = (k == 0) || (e.npcop != 2'd0);
                chk_state = 1'b1;
                exp_valid = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multicycle MIPS core. Sequences each instruction through IF/ID/EX/MEM/WB and drives every datapath enable and select, including the sign-extender's `EXTOp`. Sits beside the datapath. Consumes `Op`/`Funct` from the instruction register and `Zero` from the ALU.

## Interface
- No parameters. All encodings come from `signal_def.v`.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `Op` in 6: IR[31:26].
- `Funct` in 6: IR[5:0].
- `Zero` in 1: ALU zero flag, valid in EX.
- `PCWr` out 1: PC write enable.
- `IRWr` out 1: instruction register write enable.
- `RegWr` out 1: register file write enable.
- `MemWr` out 1: data memory write enable.
- `EXTOp` out 2: extender mode (`EXTOP_UNSIGNED`=00, `EXTOP_SIGNED`=01, `EXTOP_INST`=10).
- `ALUOp` out 3: ALU function (ADD, SUB, OR, SLT, LUI).
- `ALUSrcB` out 1: 0 selects B register, 1 selects extended immediate.
- `RegDst` out 2: write address select; 0=rt, 1=rd, 2=$31.
- `MemToReg` out 2: write data select; 0=ALU, 1=memory, 2=PC+4.
- `NPCOp` out 2: next-PC select; 0=PC+4, 1=branch, 2=jump target, 3=register.
- `InstDone` out 1: one-cycle pulse in the final state of each instruction.
- `Illegal` out 1: one-cycle pulse in ID when the opcode or funct is undecoded.
- `State` out 3: current state, for debug.

## Operation
- States are S_IF=0, S_ID=1, S_EX=2, S_MEM=3, S_WB=4. The state register is the only storage.
- Supported instructions:
  - R-type (Op=000000): addu (Funct 100001), subu (100011), slt (101010), jr (001000).
  - I-type: ori 001101, addiu 001001, lui 001111, lw 100011, sw 101011, beq 000100.
  - J-type: j 000010, jal 000011.
- **S_IF:** `PCWr`=1, `IRWr`=1, `NPCOp`=0. Always goes to S_ID.
- **S_ID:** registers are read and the immediate is extended.
  - j: `PCWr`=1, `NPCOp`=2. Done; go to S_IF.
  - jal: same as j, plus `RegWr`=1, `RegDst`=2, `MemToReg`=2. Done; go to S_IF.
  - jr: `PCWr`=1, `NPCOp`=3. Done; go to S_IF.
  - Illegal opcode or funct: `Illegal`=1, no write enables, go to S_IF. `InstDone` stays 0.
  - All other instructions: go to S_EX.
- **S_EX:**
  - beq: `ALUOp`=SUB, `ALUSrcB`=0. `PCWr`=`Zero`, `NPCOp`=1. Done; go to S_IF.
  - lw/sw: `ALUOp`=ADD, `ALUSrcB`=1. Go to S_MEM.
  - Everything else: go to S_WB.
- **S_MEM:**
  - sw: `MemWr`=1. Done; go to S_IF.
  - lw: go to S_WB.
- **S_WB:** `RegWr`=1. Done; go to S_IF.
  - R-type: `RegDst`=1, `MemToReg`=0.
  - I-type ALU ops: `RegDst`=0, `MemToReg`=0.
  - lw: `RegDst`=0, `MemToReg`=1.
- `EXTOp` is a pure function of `Op`, stable for the whole instruction because IR changes only in S_IF:
  - ori and lui: UNSIGNED.
  - addiu, lw, sw, beq: SIGNED.
  - All others: INST.
- `ALUOp` and `ALUSrcB` are held at their S_EX values through S_MEM and S_WB. This keeps the ALU result stable.
- Write enables (`PCWr`, `IRWr`, `RegWr`, `MemWr`) are asserted only in the listed states and are 0 everywhere else.

## Timing
- Moore outputs are decoded from `State` and `Op`/`Funct`. The one exception is `PCWr` in beq S_EX, which also depends on the same-cycle `Zero`.
- While `rst`=1:
  - `State`=S_IF.
  - All write enables, `InstDone` and `Illegal` are 0.
  - `EXTOp`, `ALUOp`, `ALUSrcB`, `RegDst`, `MemToReg` and `NPCOp` are 0.
  - The first instruction fetch is the first edge after `rst` falls.
- `rst` asserted in any state aborts the instruction at the next edge. No further write enable pulses occur.
- Cycles per instruction:
  - j, jal, jr, illegal: 2.
  - beq: 3.
  - sw: 4.
  - R-type ALU, ori, addiu, lui: 4.
  - lw: 5.
- `InstDone` is high for exactly one cycle per retired instruction. That cycle is the one in which the instruction's final write occurs, or, for beq, the one in which the branch resolves.

## Structure
- Shared definitions go in `signal_def.v`: state encodings, `EXTOP_*`, `ALUOP_*`, `NPC_*`, `REGDST_*`, `MEMTOREG_*`, and the opcode/funct constants.
- No sub-module: one state register plus combinational next-state and output decode.

## Test plan
- Reset with `rst` held 3 cycles and `Op`=100011: all outputs 0 and `State`=0. Release `rst` -> S_IF with `PCWr`=`IRWr`=1.
- lw (Op 100011): state sequence 0,1,2,3,4.
  - `EXTOp`=01 throughout.
  - `RegWr`=1, `MemToReg`=1 only in cycle 5.
  - `InstDone` pulses in cycle 5.
- beq (Op 000100), `Zero`=1 then `Zero`=0 run: 3 cycles each. `PCWr`=1 with `NPCOp`=1 in S_EX only when `Zero`=1.
- jal (Op 000011): 2 cycles. In S_ID, `PCWr`=1, `NPCOp`=2, `RegWr`=1, `RegDst`=2, `MemToReg`=2.
- ori (001101) then addiu (001001): `EXTOp`=00, then 01. Each writes with `RegDst`=0 in S_WB.
- Illegal input (Op=111111) -> `Illegal` pulses in S_ID with zero write enables, then return to S_IF. `rst` asserted in S_MEM of sw -> `MemWr` never asserted.
